// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: sync lines under test plus the monitor's measurement readouts
interface vga_sync_monitor_if;
  logic        hSync;
  logic        vSync;
  logic [11:0] line_period;
  logic [11:0] hs_width;
  logic [9:0]  lines_per_frame;
  logic [3:0]  vs_width;
  logic        locked;
  logic        err_sticky;
  logic [7:0]  frame_count;
  modport master (
    output hSync, vSync,
    input  line_period, hs_width, lines_per_frame, vs_width, locked, err_sticky, frame_count
  );
  modport slave (
    input  hSync, vSync,
    output line_period, hs_width, lines_per_frame, vs_width, locked, err_sticky, frame_count
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures hSync/vSync timing on ClkPort and declares lock
// once LOCK_FRAMES consecutive frames match the expected VGA timing.
module vga_sync_monitor #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int H_PERIOD_EXP    = 3200,
  parameter int H_PULSE_EXP     = 384,
  parameter int V_LINES_EXP     = 525,
  parameter int V_PULSE_EXP     = 2,
  parameter int H_TOL           = 4,
  parameter int LOCK_FRAMES     = 4
) (
  input logic ClkPort,
  input logic Reset,
  vga_sync_monitor_if.slave bus
);
  localparam logic [1:0]  SEARCH    = 2'd0;
  localparam logic [1:0]  MEASURE   = 2'd1;
  localparam logic [1:0]  LOCKED    = 2'd2;
  localparam logic [11:0] HP_LO     = 12'(H_PERIOD_EXP - H_TOL);
  localparam logic [11:0] HP_HI     = 12'(H_PERIOD_EXP + H_TOL);
  localparam logic [11:0] HW_LO     = 12'(H_PULSE_EXP - H_TOL);
  localparam logic [11:0] HW_HI     = 12'(H_PULSE_EXP + H_TOL);
  localparam logic [9:0]  V_LINES   = 10'(V_LINES_EXP);
  localparam logic [3:0]  V_PULSE   = 4'(V_PULSE_EXP);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 1);

  logic [1:0]  hs_sync_q, vs_sync_q;
  logic        hs_prev_q, vs_prev_q;
  logic [11:0] hcnt_q, hcnt_d;
  logic [9:0]  lcnt_q, lcnt_d;
  logic [3:0]  vlcnt_q, vlcnt_d;
  logic [11:0] line_period_q, line_period_d;
  logic [11:0] hs_width_q, hs_width_d;
  logic [9:0]  lpf_q, lpf_d;
  logic [3:0]  vs_width_q, vs_width_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        err_q, err_d;
  logic        hs_start, hs_end, vs_start, vs_end, vs_on, timeout, good_frame, in_locked;

  // Polarity is folded in ahead of the synchronizer so the all-zero reset
  // state reads as "deasserted" and release never fakes a sync edge.
  assign vs_on    = vs_sync_q[1];
  assign hs_start = hs_sync_q[1] & ~hs_prev_q;
  assign hs_end   = ~hs_sync_q[1] & hs_prev_q;
  assign vs_start = vs_on & ~vs_prev_q;
  assign vs_end   = ~vs_on & vs_prev_q;
  assign in_locked = state_q == LOCKED;

  always_comb begin
    hcnt_d        = hs_start ? 12'd0 : (hcnt_q == 12'hfff ? hcnt_q : hcnt_q + 12'd1);
    line_period_d = hs_start ? hcnt_q + 12'd1 : line_period_q;
    hs_width_d    = hs_end ? hcnt_q + 12'd1 : hs_width_q;
    lcnt_d        = vs_start ? 10'd0 : lcnt_q + {9'd0, hs_start};
    lpf_d         = vs_start ? lcnt_q + {9'd0, hs_start} : lpf_q;
    vlcnt_d       = vs_end ? 4'd0 : (hs_start && vs_on && vlcnt_q != 4'hf) ? vlcnt_q + 4'd1 : vlcnt_q;
    vs_width_d    = vs_end ? vlcnt_q : vs_width_q;
    timeout       = hcnt_d == 12'hfff;
    good_frame    = line_period_d >= HP_LO && line_period_d <= HP_HI &&
                    hs_width_d >= HW_LO && hs_width_d <= HW_HI &&
                    lpf_d == V_LINES && vs_width_d == V_PULSE;
    state_d       = timeout ? SEARCH :
                    !vs_start ? state_q :
                    state_q == SEARCH ? MEASURE :
                    state_q == MEASURE ? ((good_frame && good_cnt_q == LOCK_LAST) ? LOCKED : MEASURE) :
                    good_frame ? LOCKED : SEARCH;
    good_cnt_d    = state_q == SEARCH ? 8'd0 :
                    (state_q == MEASURE && vs_start) ? (good_frame ? good_cnt_q + 8'd1 : 8'd0) :
                    good_cnt_q;
    frame_count_d = frame_count_q + {7'd0, in_locked & vs_start};
    err_d         = err_q | (in_locked & (timeout | (vs_start & ~good_frame)));
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      hs_sync_q     <= '0;
      vs_sync_q     <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      vlcnt_q       <= '0;
      line_period_q <= '0;
      hs_width_q    <= '0;
      lpf_q         <= '0;
      vs_width_q    <= '0;
      state_q       <= SEARCH;
      good_cnt_q    <= '0;
      frame_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      hs_sync_q     <= {hs_sync_q[0], bus.hSync ^ SYNC_ACTIVE_LOW};
      vs_sync_q     <= {vs_sync_q[0], bus.vSync ^ SYNC_ACTIVE_LOW};
      hs_prev_q     <= hs_sync_q[1];
      vs_prev_q     <= vs_sync_q[1];
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      vlcnt_q       <= vlcnt_d;
      line_period_q <= line_period_d;
      hs_width_q    <= hs_width_d;
      lpf_q         <= lpf_d;
      vs_width_q    <= vs_width_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  assign bus.line_period     = line_period_q;
  assign bus.hs_width        = hs_width_q;
  assign bus.lines_per_frame = lpf_q;
  assign bus.vs_width        = vs_width_q;
  assign bus.locked          = in_locked;
  assign bus.err_sticky      = err_q;
  assign bus.frame_count     = frame_count_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of vga_sync_monitor on a shortened
// timing (24-cycle lines, 6-cycle hsync, 4-line frames, 2-line vsync).
module tb_vga_sync_monitor;
  localparam int PER = 24, PW = 6, LINES = 4, VW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs_a = 1'b0, vs_a = 1'b0, pol2 = 1'b1;
  int n_cmp = 0, n_err = 0;

  vga_sync_monitor_if b1();
  vga_sync_monitor_if b2();
  assign b1.hSync = ~hs_a;
  assign b1.vSync = ~vs_a;
  assign b2.hSync = pol2 ? hs_a : ~hs_a;
  assign b2.vSync = pol2 ? vs_a : ~vs_a;

  vga_sync_monitor #(.SYNC_ACTIVE_LOW(1'b1), .H_PERIOD_EXP(PER), .H_PULSE_EXP(PW),
    .V_LINES_EXP(LINES), .V_PULSE_EXP(VW), .H_TOL(4), .LOCK_FRAMES(4))
    dut1 (.ClkPort(clk), .Reset(rst), .bus(b1));
  vga_sync_monitor #(.SYNC_ACTIVE_LOW(1'b0), .H_PERIOD_EXP(PER), .H_PULSE_EXP(PW),
    .V_LINES_EXP(LINES), .V_PULSE_EXP(VW), .H_TOL(4), .LOCK_FRAMES(4))
    dut2 (.ClkPort(clk), .Reset(rst), .bus(b2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int per, input int pw, input bit vs);
    for (int t = 0; t < per; t++) begin
      hs_a = t < pw;
      vs_a = vs;
      tick();
    end
  endtask

  task automatic run_frame(input int per, input int pw, input int lines);
    for (int l = 0; l < lines; l++) run_line(per, pw, l < VW);
  endtask

  task automatic run_frames(input int n, input int per, input int pw);
    repeat (n) run_frame(per, pw, LINES);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    hs_a = 1'b0;
    vs_a = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hs_a = i[0];
      vs_a = i[1];
      tick();
    end
    n_cmp++;
    if ({b1.line_period, b1.hs_width, b1.lines_per_frame, b1.vs_width, b1.locked, b1.err_sticky, b1.frame_count} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_dut1: got lp=%0d hw=%0d lpf=%0d vw=%0d lk=%b err=%b fc=%0d want all 0",
        b1.line_period, b1.hs_width, b1.lines_per_frame, b1.vs_width, b1.locked, b1.err_sticky, b1.frame_count);
    end
    n_cmp++;
    if ({b2.line_period, b2.hs_width, b2.lines_per_frame, b2.vs_width, b2.locked, b2.err_sticky, b2.frame_count} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_dut2: got lp=%0d hw=%0d lpf=%0d vw=%0d lk=%b err=%b fc=%0d want all 0",
        b2.line_period, b2.hs_width, b2.lines_per_frame, b2.vs_width, b2.locked, b2.err_sticky, b2.frame_count);
    end
  endtask

  task automatic test_ideal();
    apply_reset();
    run_frames(4, PER, PW);
    n_cmp++;
    if (b1.locked !== 1'b0) begin n_err++; $display("FAIL ideal_early_lock: got %b want 0", b1.locked); end
    run_frames(1, PER, PW);
    n_cmp++;
    if (b1.locked !== 1'b1) begin n_err++; $display("FAIL ideal_lock: got %b want 1", b1.locked); end
    n_cmp++;
    if ({b1.line_period, b1.hs_width, b1.lines_per_frame, b1.vs_width} !== {12'd24, 12'd6, 10'd4, 4'd2}) begin
      n_err++;
      $display("FAIL ideal_readout: got %0d/%0d/%0d/%0d want 24/6/4/2", b1.line_period, b1.hs_width, b1.lines_per_frame, b1.vs_width);
    end
    n_cmp++;
    if ({b1.err_sticky, b1.frame_count} !== 9'd0) begin
      n_err++;
      $display("FAIL ideal_err_fc: got err=%b fc=%0d want 0/0", b1.err_sticky, b1.frame_count);
    end
    run_frames(1, PER, PW);
    n_cmp++;
    if (b1.frame_count !== 8'd1) begin n_err++; $display("FAIL ideal_fc: got %0d want 1", b1.frame_count); end
  endtask

  task automatic test_tolerance();
    int cases [6][3] = '{'{28, 2, 1}, '{20, 10, 1}, '{29, 6, 0}, '{19, 6, 0}, '{24, 11, 0}, '{24, 1, 0}};
    for (int c = 0; c < 6; c++) begin
      apply_reset();
      run_frames(6, cases[c][0], cases[c][1]);
      n_cmp++;
      if (b1.locked !== 1'(cases[c][2])) begin
        n_err++;
        $display("FAIL tol_lock p=%0d w=%0d: got %b want %0d", cases[c][0], cases[c][1], b1.locked, cases[c][2]);
      end
      n_cmp++;
      if (b1.line_period !== 12'(cases[c][0])) begin
        n_err++;
        $display("FAIL tol_period: got %0d want %0d", b1.line_period, cases[c][0]);
      end
      n_cmp++;
      if (b1.hs_width !== 12'(cases[c][1])) begin
        n_err++;
        $display("FAIL tol_width: got %0d want %0d", b1.hs_width, cases[c][1]);
      end
      n_cmp++;
      if (b1.err_sticky !== 1'b0) begin n_err++; $display("FAIL tol_err: got %b want 0", b1.err_sticky); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    run_frames(5, PER, PW);
    n_cmp++;
    if (b1.locked !== 1'b1) begin n_err++; $display("FAIL timeout_pre_lock: got %b want 1", b1.locked); end
    hs_a = 1'b1;
    vs_a = 1'b0;
    repeat (PW) tick();
    hs_a = 1'b0;
    // hs_start acts on the 3rd of these edges; hcnt reaches 4095 on edge 4097
    repeat (4097 - PW) tick();
    n_cmp++;
    if (b1.locked !== 1'b1) begin n_err++; $display("FAIL timeout_early: got %b want 1", b1.locked); end
    tick();
    n_cmp++;
    if ({b1.locked, b1.err_sticky} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_drop: got lk=%b err=%b want 0/1", b1.locked, b1.err_sticky);
    end
    n_cmp++;
    if (b1.line_period !== 12'd24) begin n_err++; $display("FAIL timeout_hold: got %0d want 24", b1.line_period); end
  endtask

  task automatic test_short_frame();
    apply_reset();
    run_frames(6, PER, PW);
    n_cmp++;
    if ({b1.locked, b1.frame_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL short_pre: got lk=%b fc=%0d want 1/1", b1.locked, b1.frame_count);
    end
    run_frame(PER, PW, LINES - 1);
    n_cmp++;
    if ({b1.locked, b1.frame_count} !== {1'b1, 8'd2}) begin
      n_err++;
      $display("FAIL short_unjudged: got lk=%b fc=%0d want 1/2", b1.locked, b1.frame_count);
    end
    run_frames(1, PER, PW);
    n_cmp++;
    if ({b1.locked, b1.err_sticky, b1.lines_per_frame, b1.frame_count} !== {1'b0, 1'b1, 10'd3, 8'd3}) begin
      n_err++;
      $display("FAIL short_drop: got lk=%b err=%b lpf=%0d fc=%0d want 0/1/3/3", b1.locked, b1.err_sticky, b1.lines_per_frame, b1.frame_count);
    end
    run_frames(4, PER, PW);
    n_cmp++;
    if (b1.locked !== 1'b0) begin n_err++; $display("FAIL short_early_relock: got %b want 0", b1.locked); end
    run_frames(1, PER, PW);
    n_cmp++;
    if ({b1.locked, b1.err_sticky, b1.lines_per_frame, b1.frame_count} !== {1'b1, 1'b1, 10'd4, 8'd3}) begin
      n_err++;
      $display("FAIL short_relock: got lk=%b err=%b lpf=%0d fc=%0d want 1/1/4/3", b1.locked, b1.err_sticky, b1.lines_per_frame, b1.frame_count);
    end
  endtask

  task automatic test_polarity();
    pol2 = 1'b1;
    apply_reset();
    run_frames(4, PER, PW);
    n_cmp++;
    if (b2.locked !== 1'b0) begin n_err++; $display("FAIL pol_early_lock: got %b want 0", b2.locked); end
    run_frames(1, PER, PW);
    n_cmp++;
    if ({b2.locked, b2.err_sticky} !== 2'b10) begin
      n_err++;
      $display("FAIL pol_lock: got lk=%b err=%b want 1/0", b2.locked, b2.err_sticky);
    end
    n_cmp++;
    if ({b2.line_period, b2.hs_width, b2.lines_per_frame, b2.vs_width} !== {12'd24, 12'd6, 10'd4, 4'd2}) begin
      n_err++;
      $display("FAIL pol_readout: got %0d/%0d/%0d/%0d want 24/6/4/2", b2.line_period, b2.hs_width, b2.lines_per_frame, b2.vs_width);
    end
    pol2 = 1'b0;
    apply_reset();
    run_frames(6, PER, PW);
    n_cmp++;
    if ({b2.locked, b2.hs_width, b2.line_period} !== {1'b0, 12'd18, 12'd24}) begin
      n_err++;
      $display("FAIL pol_wrong_sense: got lk=%b hw=%0d lp=%0d want 0/18/24", b2.locked, b2.hs_width, b2.line_period);
    end
    pol2 = 1'b1;
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    run_frames(5, PER, PW);
    run_frames(255, PER, PW);
    n_cmp++;
    if ({b1.locked, b1.frame_count} !== {1'b1, 8'd255}) begin
      n_err++;
      $display("FAIL wrap_255: got lk=%b fc=%0d want 1/255", b1.locked, b1.frame_count);
    end
    run_frames(1, PER, PW);
    n_cmp++;
    if ({b1.locked, b1.frame_count} !== {1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL wrap_0: got lk=%b fc=%0d want 1/0", b1.locked, b1.frame_count);
    end
    run_line(PER, PW, 1'b1);
    hs_a = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({b1.locked, b1.frame_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL wrap_pre_reset: got lk=%b fc=%0d want 1/1", b1.locked, b1.frame_count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({b1.line_period, b1.hs_width, b1.lines_per_frame, b1.vs_width, b1.locked, b1.err_sticky, b1.frame_count} !== 48'd0) begin
      n_err++;
      $display("FAIL async_reset: got lp=%0d hw=%0d lpf=%0d vw=%0d lk=%b fc=%0d want all 0",
        b1.line_period, b1.hs_width, b1.lines_per_frame, b1.vs_width, b1.locked, b1.frame_count);
    end
    hs_a = 1'b0;
    vs_a = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_frames(5, PER, PW);
    n_cmp++;
    if ({b1.locked, b1.err_sticky, b1.frame_count} !== {1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL post_reset_relock: got lk=%b err=%b fc=%0d want 1/0/0", b1.locked, b1.err_sticky, b1.frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_tolerance();
    test_timeout();
    test_short_frame();
    test_polarity();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
Receive-side checker for the VGA timing that the display controller drives onto hSync/vSync. It samples both sync lines on ClkPort and measures line period, hsync width, lines per frame and vsync width. It then declares lock against the expected 640x480@60 timing. It sits beside the display controller in the VGA top; its outputs feed the SSDs and LEDs for bring-up and regression checks.

Parameters:
SYNC_ACTIVE_LOW, 1, 1 = sync pulses are asserted low, 0 = asserted high
H_PERIOD_EXP, 3200, expected ClkPort cycles per line (800 px x 4)
H_PULSE_EXP, 384, expected hsync asserted cycles (96 px x 4)
V_LINES_EXP, 525, expected lines per frame
V_PULSE_EXP, 2, expected vsync asserted lines
H_TOL, 4, allowed +/- cycle error on H_PERIOD_EXP and H_PULSE_EXP; vertical checks are exact
LOCK_FRAMES, 4, consecutive good frames required to lock

Ports:
ClkPort  in  1  100 MHz system clock
Reset  in  1  asynchronous, active-high reset
hSync  in  1  horizontal sync under test
vSync  in  1  vertical sync under test
line_period  out  12  last measured hsync-to-hsync cycles
hs_width  out  12  last measured hsync asserted cycles
lines_per_frame  out  10  last measured hsync starts per frame
vs_width  out  4  last measured vsync asserted lines
locked  out  1  timing matches expectations
err_sticky  out  1  set on loss of lock; cleared only by Reset
frame_count  out  8  vsync starts counted while locked

Behaviour:
- Reset is asynchronous and active-high; clock is ClkPort. While Reset=1, every output and internal register is 0 and the state is SEARCH. Reset asserted mid-frame takes effect immediately. There is no partial-frame carryover after release.
- Input path: a 2-flop synchronizer on each sync, then normalisation to active-high (inverted when SYNC_ACTIVE_LOW=1), then a previous-value register. hs_start/hs_end and vs_start/vs_end are single-cycle pulses on the asserting and deasserting edges. Pin edge to pulse latency is 3 cycles. All measurements are relative, so the latency cancels.
- hcnt (12 b) increments every cycle and saturates at 4095.
  - On hs_start: line_period <= hcnt+1, then hcnt <= 0.
  - On hs_end: hs_width <= hcnt+1.
- lcnt (10 b) increments on hs_start.
  - On vs_start: lines_per_frame <= lcnt, counting an hs_start in the same cycle. Then lcnt <= 0.
- vlcnt (4 b, saturating at 15) counts hs_start while vsync is asserted.
  - On vs_end: vs_width <= vlcnt, then vlcnt <= 0.
- good_frame is evaluated at vs_start using the values latched at that moment. It is true when all of the following hold:
  - |line_period-H_PERIOD_EXP| <= H_TOL
  - |hs_width-H_PULSE_EXP| <= H_TOL
  - lines_per_frame = V_LINES_EXP, using the value latched that same cycle
  - vs_width = V_PULSE_EXP
- FSM:
  - SEARCH: locked=0. The first vs_start goes to MEASURE with good_cnt=0. The first frame is partial and is never judged.
  - MEASURE: on each vs_start, if good_frame then good_cnt++, else good_cnt <= 0. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1 on the next cycle.
  - LOCKED: each vs_start increments frame_count, wrapping 255->0. If good_frame=0 at a vs_start, go to SEARCH with locked=0 and err_sticky=1. The frame_count increment for that vs_start still occurs.
- Timeout: if hcnt reaches 4095 (no hs_start for 4096 cycles) in any state:
  - go to SEARCH and set locked=0;
  - set err_sticky=1 if the state was LOCKED;
  - measurement outputs hold their last values.
- Simultaneous hs_start and vs_start: horizontal latching happens first, and both take effect in the same cycle as defined above.
- Measurement outputs update in every state.

Test Plan:
1. Ideal timing generator (period 3200, hsync 384, 525 lines, vsync 2 lines, active-low) -> locked=1 after first vs_start + 4 good frames. Readouts: 3200 / 384 / 525 / 2, err_sticky=0.
2. Line period 3204, then 3205 -> 3204 locks. 3205 never locks; line_period reads 3205 and err_sticky stays 0.
3. Lock, then hold hSync inactive -> locked=0 exactly 4095 cycles after the last hs_start pulse, err_sticky=1, line_period holds 3200.
4. Lock, then emit one frame of 524 lines -> at that frame's vs_start locked=0 and err_sticky=1. Restore 525 -> relock after 1+4 frames; err_sticky stays 1.
5. SYNC_ACTIVE_LOW=0 with inverted stimulus -> same lock and readouts as test 1. Active-low stimulus into this build -> hs_width reads 2816 and no lock.
6. Locked for 260 frames, then assert Reset mid-line -> frame_count passes 255->0 before reset. During Reset all outputs are 0 in the same cycle; after release, relock within 5 frames.
